// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_ctrl_pkg
// Description : Shared constants and types for the multi-cycle RV32I control
//               unit: opcodes, FSM states, instruction classes, mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    // Major opcodes accepted by the core
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // FSM states; the encoding is visible on the debug state output
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Instruction classes produced by the decoder
    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_I       = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } instr_class_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_B = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Branch funct3 codes; 010/011 are reserved and trap
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV0 = 3'b010;
    localparam logic [2:0] F3_RSV1 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Bundle between the control FSM and the datapath/memory:
//               instruction, comparator flags, memory handshake and all
//               datapath control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if;
    logic [31:0] instr;
    logic        breq;
    logic        brlt;
    logic        mem_ready;

    logic        pc_wr_en;
    logic        ir_wr_en;
    logic        pc_sel;
    logic        a_sel;
    logic        b_sel;
    logic        br_un;
    logic        mem_req;
    logic        mem_write_en;
    logic        reg_file_wr_en;
    logic [3:0]  alu_sel;
    logic [1:0]  wb_sel;
    logic [2:0]  imm_sel;
    logic [2:0]  state;
    logic        illegal;
    logic        halted;

    // Controller side
    modport master (
        input  instr, breq, brlt, mem_ready,
        output pc_wr_en, ir_wr_en, pc_sel, a_sel, b_sel, br_un, mem_req,
               mem_write_en, reg_file_wr_en, alu_sel, wb_sel, imm_sel,
               state, illegal, halted
    );

    // Datapath / memory side
    modport slave (
        output instr, breq, brlt, mem_ready,
        input  pc_wr_en, ir_wr_en, pc_sel, a_sel, b_sel, br_un, mem_req,
               mem_write_en, reg_file_wr_en, alu_sel, wb_sel, imm_sel,
               state, illegal, halted
    );
endinterface
`default_nettype wire

// File: rtl/mcu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mcu_decoder
// Description : Combinational opcode/funct3 classification for the
//               multi-cycle control unit. Flags unsupported opcodes and the
//               reserved branch funct3 codes as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    input  logic [2:0]   funct3,
    output instr_class_t instr_class,
    output logic         illegal
);

    // Map opcode (and branch funct3) to an instruction class
    always_comb begin
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OPC_OP:     instr_class = CLS_R;
            OPC_OP_IMM: instr_class = CLS_I;
            OPC_LOAD:   instr_class = CLS_LOAD;
            OPC_STORE:  instr_class = CLS_STORE;
            OPC_JAL:    instr_class = CLS_JAL;
            OPC_JALR:   instr_class = CLS_JALR;
            OPC_LUI:    instr_class = CLS_LUI;
            OPC_AUIPC:  instr_class = CLS_AUIPC;
            OPC_BRANCH: begin
                if (funct3 == F3_RSV0 || funct3 == F3_RSV1) begin
                    instr_class = CLS_ILLEGAL;
                end else begin
                    instr_class = CLS_BRANCH;
                end
            end
            default:    instr_class = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (instr_class == CLS_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Control FSM for the multi-cycle RV32I core. Sequences each
//               instruction through FETCH/DECODE/EXEC/MEM/WB over a shared
//               req/ready memory, traps on illegal opcodes and memory timeout.
//               Optional feature macro: MCU_RETIRE_CNT_EN adds retire_cnt,
//               counting cycles with pc_wr_en asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    multicycle_control_unit_if.master  bus
`ifdef MCU_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0]           retire_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    if (MEM_TIMEOUT < 1 || CNT_W < 1) begin : g_param_check
        $error("multicycle_control_unit: MEM_TIMEOUT and CNT_W must be >= 1");
    end

    state_t            state_q;
    state_t            state_d;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_expired;
    instr_class_t      cls;
    logic              dec_illegal;
    logic [2:0]        funct3;
    logic              br_taken;

    logic              op_a_sel;
    logic              op_b_sel;
    logic [2:0]        op_imm_sel;
    logic [3:0]        op_alu_sel;

    logic              pc_wr_en;
    logic              ir_wr_en;
    logic              pc_sel;
    logic              a_sel;
    logic              b_sel;
    logic              br_un;
    logic              mem_req;
    logic              mem_write_en;
    logic              reg_file_wr_en;
    logic [3:0]        alu_sel;
    logic [1:0]        wb_sel;
    logic [2:0]        imm_sel;
    logic              illegal;

    assign funct3       = bus.instr[14:12];
    // A ready arriving on the limit cycle wins over the timeout
    assign wait_expired = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

    mcu_decoder u_decoder (
        .opcode      (bus.instr[6:0]),
        .funct3      (funct3),
        .instr_class (cls),
        .illegal     (dec_illegal)
    );

    // Branch condition from the comparator flags
    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            F3_BEQ:           br_taken = bus.breq;
            F3_BNE:           br_taken = !bus.breq;
            F3_BLT, F3_BLTU:  br_taken = bus.brlt;
            F3_BGE, F3_BGEU:  br_taken = !bus.brlt;
            default:          br_taken = 1'b0;
        endcase
    end

    // ALU operand selects per class; held from EXEC through MEM/WB
    always_comb begin
        op_a_sel   = 1'b0;
        op_b_sel   = 1'b0;
        op_imm_sel = IMM_I;
        op_alu_sel = ALU_ADD;
        case (cls)
            CLS_R:      op_alu_sel = {bus.instr[30], funct3};
            CLS_I:      begin op_alu_sel = {1'b0, funct3}; op_b_sel = 1'b1; end
            CLS_LOAD:   op_b_sel = 1'b1;
            CLS_STORE:  begin op_b_sel = 1'b1; op_imm_sel = IMM_S; end
            CLS_LUI:    begin op_b_sel = 1'b1; op_imm_sel = IMM_U; end
            CLS_AUIPC:  begin op_a_sel = 1'b1; op_b_sel = 1'b1; op_imm_sel = IMM_U; end
            CLS_JAL:    begin op_a_sel = 1'b1; op_b_sel = 1'b1; op_imm_sel = IMM_J; end
            CLS_JALR:   op_b_sel = 1'b1;
            CLS_BRANCH: begin op_a_sel = 1'b1; op_b_sel = 1'b1; op_imm_sel = IMM_B; end
            default:    ;
        endcase
    end

    // Next-state and control outputs; everything forced quiet under reset
    always_comb begin
        state_d        = state_q;
        pc_wr_en       = 1'b0;
        ir_wr_en       = 1'b0;
        pc_sel         = 1'b0;
        a_sel          = 1'b0;
        b_sel          = 1'b0;
        br_un          = 1'b0;
        mem_req        = 1'b0;
        mem_write_en   = 1'b0;
        reg_file_wr_en = 1'b0;
        alu_sel        = ALU_ADD;
        wb_sel         = WB_MEM;
        imm_sel        = IMM_I;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_wr_en = 1'b1;
                    state_d  = ST_DECODE;
                end else if (wait_expired) begin
                    state_d  = ST_TRAP;
                end
            end
            ST_DECODE: begin
                state_d = dec_illegal ? ST_TRAP : ST_EXEC;
            end
            ST_EXEC: begin
                a_sel   = op_a_sel;
                b_sel   = op_b_sel;
                imm_sel = op_imm_sel;
                alu_sel = op_alu_sel;
                case (cls)
                    CLS_BRANCH: begin
                        pc_wr_en = 1'b1;
                        pc_sel   = br_taken;
                        br_un    = funct3[1];
                        state_d  = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                a_sel        = op_a_sel;
                b_sel        = op_b_sel;
                imm_sel      = op_imm_sel;
                alu_sel      = op_alu_sel;
                mem_req      = 1'b1;
                mem_write_en = (cls == CLS_STORE);
                if (bus.mem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_wr_en = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d  = ST_WB;
                    end
                end else if (wait_expired) begin
                    state_d = ST_TRAP;
                end
            end
            ST_WB: begin
                a_sel          = op_a_sel;
                b_sel          = op_b_sel;
                imm_sel        = op_imm_sel;
                alu_sel        = op_alu_sel;
                reg_file_wr_en = 1'b1;
                pc_wr_en       = 1'b1;
                state_d        = ST_FETCH;
                case (cls)
                    CLS_JAL, CLS_JALR: begin wb_sel = WB_PC4; pc_sel = 1'b1; end
                    CLS_LOAD:          wb_sel = WB_MEM;
                    default:           wb_sel = WB_ALU;
                endcase
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase

        illegal = (state_q != ST_TRAP) && (state_d == ST_TRAP);

        if (rst) begin
            pc_wr_en       = 1'b0;
            ir_wr_en       = 1'b0;
            pc_sel         = 1'b0;
            a_sel          = 1'b0;
            b_sel          = 1'b0;
            br_un          = 1'b0;
            mem_req        = 1'b0;
            mem_write_en   = 1'b0;
            reg_file_wr_en = 1'b0;
            alu_sel        = ALU_ADD;
            wb_sel         = WB_MEM;
            imm_sel        = IMM_I;
            illegal        = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory wait counter: cleared on any state change or on ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_d != state_q) begin
            wait_cnt <= '0;
        end else if (bus.mem_ready) begin
            wait_cnt <= '0;
        end else if (state_q == ST_FETCH || state_q == ST_MEM) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

`ifdef MCU_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q;

    // Retire counter: one tick per PC update, frozen once trapped
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_q <= '0;
        end else if (pc_wr_en && state_q != ST_TRAP) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign retire_cnt = retire_q;
`endif

    assign bus.pc_wr_en       = pc_wr_en;
    assign bus.ir_wr_en       = ir_wr_en;
    assign bus.pc_sel         = pc_sel;
    assign bus.a_sel          = a_sel;
    assign bus.b_sel          = b_sel;
    assign bus.br_un          = br_un;
    assign bus.mem_req        = mem_req;
    assign bus.mem_write_en   = mem_write_en;
    assign bus.reg_file_wr_en = reg_file_wr_en;
    assign bus.alu_sel        = alu_sel;
    assign bus.wb_sel         = wb_sel;
    assign bus.imm_sel        = imm_sel;
    assign bus.state          = state_q;
    assign bus.illegal        = illegal;
    assign bus.halted         = (state_q == ST_TRAP) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. A per-class
//               expectation table plus latency-driven sequencing predicts
//               every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_control_unit_if bus_if ();

`ifdef MCU_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt;
`endif

    multicycle_control_unit #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
`ifdef MCU_RETIRE_CNT_EN
        ,
        .retire_cnt (retire_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int retire_model = 0;

    // All outputs packed: {pcw,irw,pcs,a,b,bu,mreq,mwe,rfw,alu[4],wb[2],imm[3],state[3],ill,hlt}
    logic [22:0] obs;
    assign obs = {bus_if.pc_wr_en, bus_if.ir_wr_en, bus_if.pc_sel, bus_if.a_sel,
                  bus_if.b_sel, bus_if.br_un, bus_if.mem_req, bus_if.mem_write_en,
                  bus_if.reg_file_wr_en, bus_if.alu_sel, bus_if.wb_sel,
                  bus_if.imm_sel, bus_if.state, bus_if.illegal, bus_if.halted};

    typedef struct packed {
        logic       legal;
        logic       br;
        logic       ld;
        logic       st;
        logic       jump;
        logic       a;
        logic       b;
        logic [2:0] imm;
        logic [3:0] alu;
    } exp_t;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [22:0] vec(
        input logic pcw, input logic irw, input logic pcs, input logic as,
        input logic bs, input logic bu, input logic mr, input logic mw,
        input logic rw, input logic [3:0] alu, input logic [1:0] wb,
        input logic [2:0] imm, input logic [2:0] st, input logic ill, input logic hlt);
        return {pcw, irw, pcs, as, bs, bu, mr, mw, rw, alu, wb, imm, st, ill, hlt};
    endfunction

    // Expected operand controls straight from the instruction table
    function automatic exp_t expect_of(input logic [31:0] ins);
        exp_t       e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e = '0;
        e.legal = 1'b1;
        case (ins[6:0])
            7'b0110011: e.alu = {ins[30], f3};
            7'b0010011: begin e.alu = {1'b0, f3}; e.b = 1'b1; end
            7'b0000011: begin e.ld = 1'b1; e.b = 1'b1; end
            7'b0100011: begin e.st = 1'b1; e.b = 1'b1; e.imm = 3'b010; end
            7'b0110111: begin e.b = 1'b1; e.imm = 3'b011; end
            7'b0010111: begin e.a = 1'b1; e.b = 1'b1; e.imm = 3'b011; end
            7'b1101111: begin e.jump = 1'b1; e.a = 1'b1; e.b = 1'b1; e.imm = 3'b100; end
            7'b1100111: begin e.jump = 1'b1; e.b = 1'b1; end
            7'b1100011: begin
                e.br = 1'b1; e.a = 1'b1; e.b = 1'b1; e.imm = 3'b001;
                e.legal = (f3 != 3'b010) && (f3 != 3'b011);
            end
            default: e.legal = 1'b0;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;
            4: w[6:0] = 7'b0110111;
            5: w[6:0] = 7'b0010111;
            6: w[6:0] = 7'b1101111;
            7: w[6:0] = 7'b1100111;
            8: w[6:0] = 7'b1100011;
            default: ;
        endcase
        return w;
    endfunction

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 39);
        if (r == 0) return MEM_TIMEOUT + 1;
        if (r == 1) return MEM_TIMEOUT;
        return $urandom_range(0, 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_retire();
`ifdef MCU_RETIRE_CNT_EN
        check_eq("retire_cnt", retire_cnt, retire_model);
`endif
    endtask

    task automatic check_trap(input string tag);
        bus_if.mem_ready = 1'($urandom);
        @(negedge clk);
        check_eq(tag, obs, vec(0,0,0,0,0,0,0,0,0,4'd0,2'd0,3'd0,3'd5,0,1));
        tick();
        bus_if.mem_ready = 1'($urandom);
        @(negedge clk);
        check_eq({tag, "_sticky"}, obs, vec(0,0,0,0,0,0,0,0,0,4'd0,2'd0,3'd0,3'd5,0,1));
        tick();
    endtask

    task automatic do_reset();
        check_retire();
        rst = 1'b1;
        bus_if.mem_ready = 1'($urandom);
        bus_if.instr     = $urandom;
        @(negedge clk);
        check_eq("reset_outs", 32'({obs[22:5], obs[1:0]}), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        retire_model = 0;
        check_retire();
    endtask

    // One instruction: fw/mw = wait cycles before ready (> MEM_TIMEOUT: never)
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic beq_i, input logic blt_i, output logic trapped);
        exp_t       e;
        logic       rdy;
        logic       taken;
        logic [2:0] f3;
        e  = expect_of(ins);
        f3 = ins[14:12];
        trapped = 1'b0;
        bus_if.instr = ins;
        bus_if.breq  = beq_i;
        bus_if.brlt  = blt_i;

        for (int i = 0; i <= MEM_TIMEOUT; i++) begin
            rdy = (i == fw);
            bus_if.mem_ready = rdy;
            @(negedge clk);
            check_eq("fetch", obs, vec(0,rdy,0,0,0,0,1,0,0,4'd0,2'd0,3'd0,3'd0,
                                       !rdy && i == MEM_TIMEOUT, 0));
            tick();
            if (rdy) break;
        end
        if (fw > MEM_TIMEOUT) begin
            check_trap("fetch_timeout");
            trapped = 1'b1;
            return;
        end

        bus_if.mem_ready = 1'($urandom);
        @(negedge clk);
        check_eq("decode", obs, vec(0,0,0,0,0,0,0,0,0,4'd0,2'd0,3'd0,3'd1,!e.legal,0));
        tick();
        if (!e.legal) begin
            check_trap("illegal_trap");
            trapped = 1'b1;
            return;
        end

        bus_if.mem_ready = 1'($urandom);
        @(negedge clk);
        if (e.br) begin
            case (f3)
                3'b000:  taken = beq_i;
                3'b001:  taken = !beq_i;
                3'b100, 3'b110: taken = blt_i;
                default: taken = !blt_i;
            endcase
            check_eq("exec_branch", obs, vec(1,0,taken,e.a,e.b,(f3 >= 3'd6),0,0,0,
                                             e.alu,2'd0,e.imm,3'd2,0,0));
            retire_model++;
            tick();
            return;
        end
        check_eq("exec", obs, vec(0,0,0,e.a,e.b,0,0,0,0,e.alu,2'd0,e.imm,3'd2,0,0));
        tick();

        if (e.ld || e.st) begin
            for (int j = 0; j <= MEM_TIMEOUT; j++) begin
                rdy = (j == mw);
                bus_if.mem_ready = rdy;
                @(negedge clk);
                check_eq("mem", obs, vec(e.st && rdy,0,0,e.a,e.b,0,1,e.st,0,e.alu,2'd0,
                                         e.imm,3'd3,!rdy && j == MEM_TIMEOUT,0));
                tick();
                if (rdy) break;
            end
            if (mw > MEM_TIMEOUT) begin
                check_trap("mem_timeout");
                trapped = 1'b1;
                return;
            end
            if (e.st) begin
                retire_model++;
                return;
            end
        end

        bus_if.mem_ready = 1'($urandom);
        @(negedge clk);
        check_eq("wb", obs, vec(1,0,e.jump,e.a,e.b,0,0,0,1,e.alu,
                                e.jump ? 2'b10 : (e.ld ? 2'b00 : 2'b01),
                                e.imm,3'd4,0,0));
        retire_model++;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        tr;
        logic [31:0] ins;
        int          fw;
        int          mw;

        rst = 1'b1;
        bus_if.instr = 32'd0;
        bus_if.breq  = 1'b0;
        bus_if.brlt  = 1'b0;
        bus_if.mem_ready = 1'b0;
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, tr);               // add
        run_instr(32'h0000A283, 0, 3, 1'b0, 1'b0, tr);               // lw, 3 wait
        run_instr(32'h0050A223, 0, 0, 1'b0, 1'b0, tr);               // sw
        run_instr(32'h0020E463, 0, 0, 1'b0, 1'b1, tr);               // bltu taken
        run_instr(32'h0020E463, 0, 0, 1'b0, 1'b0, tr);               // bltu not taken
        run_instr(32'h002081B3, MEM_TIMEOUT, 0, 1'b0, 1'b0, tr);     // ready on limit
        run_instr(32'h0000A283, 1, MEM_TIMEOUT, 1'b0, 1'b0, tr);     // ready on limit
        run_instr(32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, tr);               // illegal
        do_reset();
        run_instr(32'h002081B3, MEM_TIMEOUT + 1, 0, 1'b0, 1'b0, tr); // fetch timeout
        do_reset();
        run_instr(32'h0000A283, 0, MEM_TIMEOUT + 1, 1'b0, 1'b0, tr); // mem timeout
        do_reset();

        // Reset arriving while a load waits in MEM
        bus_if.instr = 32'h0000A283;
        bus_if.mem_ready = 1'b1;
        tick();
        bus_if.mem_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check_eq("mid_mem", 32'({bus_if.state, bus_if.mem_req}), 32'({3'd3, 1'b1}));
        tick();
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_in_mem", 32'({obs[22:5], obs[1:0]}), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_eq("after_rst", 32'({bus_if.state, bus_if.mem_req, bus_if.illegal, bus_if.halted}),
                 32'({3'd0, 1'b1, 1'b0, 1'b0}));
        do_reset();

        for (int k = 0; k < 200; k++) begin
            ins = rand_instr();
            fw  = pick_wait();
            mw  = pick_wait();
            run_instr(ins, fw, mw, 1'($urandom), 1'($urandom), tr);
            if (tr) do_reset();
        end
        check_retire();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Control FSM for the multi-cycle RV32I core, replacing the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared variable-latency memory using a req/ready handshake.
- Decodes the full conditional-branch set plus lui/auipc.
- Traps on illegal opcodes and on memory timeout.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting for mem_ready before trapping (≥1)
CNT_W, 32, width of the optional retire counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
instr  in  32  instruction register contents (stable from DECODE until next FETCH completes)
breq  in  1  branch comparator: rs1==rs2
brlt  in  1  branch comparator: rs1<rs2 (signedness per br_un)
mem_ready  in  1  memory completes the current request this cycle
pc_wr_en  out  1  PC register load
ir_wr_en  out  1  instruction register load
pc_sel  out  1  0: pc+4, 1: alu result
a_sel  out  1  0: rs1, 1: pc
b_sel  out  1  0: rs2, 1: imm
br_un  out  1  1: unsigned branch compare
mem_req  out  1  memory request valid
mem_write_en  out  1  request is a write (valid only with mem_req)
reg_file_wr_en  out  1  register file write
alu_sel  out  4  {instr[30],funct3} for R-type; add=0000 otherwise
wb_sel  out  2  00 mem, 01 alu, 10 pc+4
imm_sel  out  3  000 I, 001 B, 010 S, 011 U, 100 J
state  out  3  current FSM state (debug)
illegal  out  1  one-cycle pulse entering TRAP
halted  out  1  sticky: FSM in TRAP

Behaviour:
- clk is the single clock; rst is synchronous, active-high.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. state is registered; all other outputs are combinational from state, instr and the comparator inputs.
- While rst is high: next state is FETCH, wait counter is 0, halted is 0, and every enable/req output is forced to 0. Reset takes effect mid-transaction; an outstanding request is abandoned.
- Outputs never drive X. Fields unused in a state are 0.
- FETCH:
  - mem_req=1, mem_write_en=0.
  - On mem_ready: ir_wr_en=1 that cycle, go to DECODE.
  - Otherwise hold and increment the wait counter.
- DECODE: one cycle.
  - Opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0110111, 0010111}, or branch funct3 ∈ {010, 011}: go to TRAP.
  - Otherwise go to EXEC.
- EXEC, per opcode:
  - R-type: alu_sel={instr[30],funct3}, go to WB.
  - addi/andi/ori: alu_sel={0,funct3}, b_sel=1, imm_sel=000, go to WB.
  - lw: imm_sel=000, b_sel=1, add, go to MEM.
  - sw: imm_sel=010, b_sel=1, add, go to MEM.
  - lui: imm_sel=011, b_sel=1, go to WB. The ALU passes imm via the rs1=x0 path.
  - auipc: a_sel=1, b_sel=1, imm_sel=011, go to WB.
  - jal: a_sel=1, b_sel=1, imm_sel=100, go to WB.
  - jalr: b_sel=1, imm_sel=000, go to WB.
  - Branch: a_sel=1, b_sel=1, imm_sel=001, pc_wr_en=1, go to FETCH. pc_sel by funct3:
    - 000 (beq): breq
    - 001 (bne): !breq
    - 100 (blt): brlt, br_un=0
    - 101 (bge): !brlt, br_un=0
    - 110 (bltu): brlt, br_un=1
    - 111 (bgeu): !brlt, br_un=1
- MEM:
  - mem_req=1, with mem_write_en=1 for sw. ALU controls are held as in EXEC.
  - On mem_ready, lw goes to WB.
  - On mem_ready, sw asserts pc_wr_en=1 (pc_sel=0) and goes to FETCH.
- WB: reg_file_wr_en=1, pc_wr_en=1, go to FETCH.
  - jal/jalr: wb_sel=10, pc_sel=1.
  - lw: wb_sel=00, pc_sel=0.
  - All others: wb_sel=01, pc_sel=0.
  - EXEC operand selects are re-driven so the ALU result stays valid.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and on mem_ready.
  - If the counter reaches MEM_TIMEOUT without mem_ready, go to TRAP.
  - mem_ready in the same cycle the counter reaches the limit counts as success.
- TRAP:
  - illegal pulses for 1 cycle on entry.
  - halted=1, all enables 0.
  - Exits only through rst.
- Latency: R/I-type 4 cycles, lw 5, sw 4, branch 3 (zero-wait memory).

Optional Feature:
MCU_RETIRE_CNT_EN
- Defined: adds output retire_cnt [CNT_W-1:0]. Cleared by rst, +1 on every cycle with pc_wr_en=1, wraps modulo 2^CNT_W, frozen in TRAP.
- Undefined: the port and counter are absent.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - state encodings
  - alu_sel, wb_sel and imm_sel encodings
  - branch funct3 codes
- One sub-module, mcu_decoder: combinational opcode/funct3 classification that produces instruction class and illegal flag. The FSM and counters stay in the top module.

Test Plan:
- add x3,x1,x2 (0x002081B3), mem_ready=1 always → FETCH→DECODE→EXEC→WB; reg_file_wr_en=1, wb_sel=01, alu_sel=0000 in WB; back in FETCH at cycle 4.
- lw 0x0000A283, mem_ready delayed 3 cycles in MEM → mem_req held 4 cycles; WB with wb_sel=00, reg_file_wr_en=1.
- sw 0x0050A223 → MEM with mem_req=1, mem_write_en=1, imm_sel=010; reg_file_wr_en never 1.
- bltu 0x0020E463 with brlt=1 → EXEC br_un=1, pc_sel=1, pc_wr_en=1. Repeat with brlt=0 → pc_sel=0.
- instr=0xFFFFFFFF → DECODE→TRAP; illegal pulses once; halted stays 1 until rst.
- mem_ready held 0 in FETCH (MEM_TIMEOUT=16) → TRAP after 16 wait cycles. rst asserted mid-MEM → FETCH next cycle with mem_req=0 during reset.
